tx_rate_monitor: RTL

Per-port transmit-side stage between one output-queue master port (m_axis_*_N) and the 10G MAC TX interface. It passes the AXI4-Stream through a two-entry skid buffer, one cycle of latency. It measures delivered bytes, packets and back-pressure stall cycles over a programmable window of microsecond ticks. Software uses it to verify the inter-packet-delay setting (IPD_value) applied upstream.

---
 rtl/tx_rate_monitor.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/tx_rate_monitor.sv
// tx_rate_monitor: two-entry skid buffer between an output-queue port and the
// MAC TX interface. It also counts delivered bytes, packets and stall cycles
// over a window of microsecond ticks, so software can check the inter-packet delay.
//
// state    | meaning
// ---------+----------------------------------------------
// ST_EMPTY | no beat held, m_axis_tvalid low
// ST_ONE   | output register holds a beat
// ST_TWO   | output and skid registers both hold beats
module tx_rate_monitor #(
    parameter int C_AXIS_DATA_WIDTH  = 256,
    parameter int C_AXIS_TUSER_WIDTH = 128,
    parameter int C_S_AXI_DATA_WIDTH = 32
) (
    input  logic                              axi_aclk,
    input  logic                              axi_resetn,
    input  logic                              utimer_clk,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     window_usec,
    input  logic [C_AXIS_DATA_WIDTH-1:0]      s_axis_tdata,
    input  logic [C_AXIS_DATA_WIDTH/8-1:0]    s_axis_tstrb,
    input  logic [C_AXIS_TUSER_WIDTH-1:0]     s_axis_tuser,
    input  logic                              s_axis_tlast,
    input  logic                              s_axis_tvalid,
    output logic                              s_axis_tready,
    output logic [C_AXIS_DATA_WIDTH-1:0]      m_axis_tdata,
    output logic [C_AXIS_DATA_WIDTH/8-1:0]    m_axis_tstrb,
    output logic [C_AXIS_TUSER_WIDTH-1:0]     m_axis_tuser,
    output logic                              m_axis_tlast,
    output logic                              m_axis_tvalid,
    input  logic                              m_axis_tready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     window_bytes,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     window_pkts,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     window_stalls,
    output logic                              window_valid
);

    localparam int STRB_W = C_AXIS_DATA_WIDTH / 8;
    localparam int CNT_W  = $clog2(STRB_W + 1);
    localparam int SW     = C_S_AXI_DATA_WIDTH;
    localparam int BEAT_W = C_AXIS_DATA_WIDTH + STRB_W + C_AXIS_TUSER_WIDTH + 1;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [BEAT_W-1:0] r_out;
    logic [BEAT_W-1:0] r_skid;
    logic [BEAT_W-1:0] w_in_beat;
    logic              r_s_tready;
    logic              w_in_hs;
    logic              w_out_hs;
    logic              w_stall;
    logic              w_load_out;
    logic              w_load_skid;
    logic              w_skid_to_out;

    logic [CNT_W-1:0]  w_strb_cnt;
    logic [SW-1:0]     r_bytes_acc;
    logic [SW-1:0]     r_pkts_acc;
    logic [SW-1:0]     r_stall_acc;
    logic [SW-1:0]     r_tick_cnt;
    logic [SW-1:0]     w_bytes_sum;
    logic [SW-1:0]     w_pkts_sum;
    logic [SW-1:0]     w_stall_sum;
    logic [SW:0]       w_tick_inc;
    logic              w_usec_zero;
    logic              w_close;
    logic [SW-1:0]     r_win_bytes;
    logic [SW-1:0]     r_win_pkts;
    logic [SW-1:0]     r_win_stalls;
    logic              r_win_valid;

    function automatic logic [SW-1:0] sat_add(input logic [SW-1:0] a, input logic [SW-1:0] b);
        logic [SW:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[SW] ? {SW{1'b1}} : s[SW-1:0];
    endfunction

    assign w_in_beat     = {s_axis_tdata, s_axis_tstrb, s_axis_tuser, s_axis_tlast};
    assign {m_axis_tdata, m_axis_tstrb, m_axis_tuser, m_axis_tlast} = r_out;
    assign m_axis_tvalid = (r_state != ST_EMPTY);
    assign s_axis_tready = r_s_tready;
    assign w_in_hs       = s_axis_tvalid & r_s_tready;
    assign w_out_hs      = m_axis_tvalid & m_axis_tready;
    assign w_stall       = m_axis_tvalid & ~m_axis_tready;

    // Skid-buffer next state and register load selects.
    always_comb begin
        w_state_nxt   = r_state;
        w_load_out    = 1'b0;
        w_load_skid   = 1'b0;
        w_skid_to_out = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                if (w_in_hs) begin
                    w_state_nxt = ST_ONE;
                    w_load_out  = 1'b1;
                end
            end
            ST_ONE: begin
                if (w_in_hs && w_out_hs) begin
                    w_load_out = 1'b1;
                end else if (w_in_hs) begin
                    w_state_nxt = ST_TWO;
                    w_load_skid = 1'b1;
                end else if (w_out_hs) begin
                    w_state_nxt = ST_EMPTY;
                end
            end
            ST_TWO: begin
                // s_axis_tready is low here, so only the output side can move.
                if (w_out_hs) begin
                    w_state_nxt   = ST_ONE;
                    w_skid_to_out = 1'b1;
                end
            end
            default: w_state_nxt = ST_EMPTY;
        endcase
    end

    // State register; tready is registered from the next state so it never depends on m_axis_tready combinationally.
    always_ff @(posedge axi_aclk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            r_state    <= ST_EMPTY;
            r_s_tready <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_s_tready <= (w_state_nxt != ST_TWO);
        end
    end

    // Output and skid beat registers.
    always_ff @(posedge axi_aclk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            r_out  <= '0;
            r_skid <= '0;
        end else begin
            if (w_load_out) begin
                r_out <= w_in_beat;
            end else if (w_skid_to_out) begin
                r_out <= r_skid;
            end
            if (w_load_skid) begin
                r_skid <= w_in_beat;
            end
        end
    end

    // Byte count of the beat currently on the output.
    always_comb begin
        w_strb_cnt = '0;
        for (int i = 0; i < STRB_W; i++) begin
            w_strb_cnt = w_strb_cnt + CNT_W'(m_axis_tstrb[i]);
        end
    end

    assign w_bytes_sum = sat_add(r_bytes_acc, w_out_hs ? SW'(w_strb_cnt) : '0);
    assign w_pkts_sum  = sat_add(r_pkts_acc, SW'(w_out_hs & m_axis_tlast));
    assign w_stall_sum = sat_add(r_stall_acc, SW'(w_stall));
    assign w_tick_inc  = {1'b0, r_tick_cnt} + (SW + 1)'(1);
    assign w_usec_zero = (window_usec == '0);
    assign w_close     = utimer_clk & ~w_usec_zero & (w_tick_inc >= {1'b0, window_usec});

    // Accumulators, tick counter and window snapshot; the closing cycle's own events land in the snapshot.
    always_ff @(posedge axi_aclk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            r_bytes_acc  <= '0;
            r_pkts_acc   <= '0;
            r_stall_acc  <= '0;
            r_tick_cnt   <= '0;
            r_win_bytes  <= '0;
            r_win_pkts   <= '0;
            r_win_stalls <= '0;
            r_win_valid  <= 1'b0;
        end else if (w_close) begin
            r_win_bytes  <= w_bytes_sum;
            r_win_pkts   <= w_pkts_sum;
            r_win_stalls <= w_stall_sum;
            r_win_valid  <= 1'b1;
            r_bytes_acc  <= '0;
            r_pkts_acc   <= '0;
            r_stall_acc  <= '0;
            r_tick_cnt   <= '0;
        end else begin
            r_win_valid <= 1'b0;
            r_bytes_acc <= w_bytes_sum;
            r_pkts_acc  <= w_pkts_sum;
            r_stall_acc <= w_stall_sum;
            if (w_usec_zero) begin
                r_tick_cnt <= '0;
            end else if (utimer_clk) begin
                r_tick_cnt <= w_tick_inc[SW-1:0];
            end
        end
    end

    assign window_bytes  = r_win_bytes;
    assign window_pkts   = r_win_pkts;
    assign window_stalls = r_win_stalls;
    assign window_valid  = r_win_valid;

endmodule
